// File: rtl/vd_pkg.sv
// Shared constants and types for the convolutional encoder / Viterbi decoder chain.
package vd_pkg;

    localparam int unsigned CONV_K      = 3;
    localparam int unsigned CONV_SR_W   = CONV_K - 1;
    localparam int unsigned CONV_TAIL_W = $clog2(CONV_K);

    // Generators; bit K-1 taps the current input bit.
    localparam logic [CONV_K-1:0] CONV_G0 = 3'b111;
    localparam logic [CONV_K-1:0] CONV_G1 = 3'b101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } enc_state_e;

    // {c0 (G0 parity), c1 (G1 parity)}
    typedef logic [1:0] code_sym_t;

endpackage

// File: rtl/conv_branch_parity.sv
// Combinational branch parity {c0, c1} for one trellis step; shared with the decoder BMU.
module conv_branch_parity
    import vd_pkg::*;
#(
    parameter int unsigned       K  = CONV_K,
    parameter logic [K-1:0]      G0 = CONV_G0,
    parameter logic [K-1:0]      G1 = CONV_G1
) (
    input  logic           u,
    input  logic [K-2:0]   sr,
    output code_sym_t      sym_c
);

    logic [K-1:0] w;

    // Window: current bit on top, newest history bit just below it.
    assign w     = {u, sr};
    assign sym_c = {^(w & G0), ^(w & G1)};

endmodule

// File: rtl/conv_encoder_tx.sv
// Rate-1/2 convolutional encoder with per-frame zero tail and a single registered output slot.
module conv_encoder_tx
    import vd_pkg::*;
#(
    parameter int unsigned   K  = CONV_K,
    parameter logic [K-1:0]  G0 = CONV_G0,
    parameter logic [K-1:0]  G1 = CONV_G1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_data_valid,
    input  logic        i_data_bit,
    input  logic        i_data_last,
    output logic        o_data_ready,
    output logic        o_code_valid,
    output logic [1:0]  o_code_bits,
    output logic        o_code_last,
    input  logic        i_code_ready,
    output logic        o_busy
);

    localparam int unsigned SR_W   = K - 1;
    localparam int unsigned TAIL_W = $clog2(K);

    enc_state_e        state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [TAIL_W-1:0] tail_q, tail_d;
    logic              valid_d;
    code_sym_t         bits_d;
    logic              last_d;
    logic              run_q;
    logic              slot_free;
    logic              accept;
    logic              enc_u;
    code_sym_t         enc_sym;

    // Handshake terms; run_q keeps ready low while reset is held.
    assign slot_free    = ~o_code_valid | i_code_ready;
    assign o_data_ready = run_q & ((state_q == S_IDLE) | (state_q == S_DATA)) & slot_free;
    assign accept       = i_data_valid & o_data_ready;
    assign o_busy       = (state_q != S_IDLE) | o_code_valid;

    // Tail steps flush zeros through the register.
    assign enc_u = (state_q == S_TAIL) ? 1'b0 : i_data_bit;

    conv_branch_parity #(
        .K  (K),
        .G0 (G0),
        .G1 (G1)
    ) u_parity (
        .u     (enc_u),
        .sr    (sr_q),
        .sym_c (enc_sym)
    );

    // Ready is only presented once reset has been released for a cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    // State, shift register, tail counter and output slot registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= S_IDLE;
            sr_q         <= '0;
            tail_q       <= '0;
            o_code_valid <= 1'b0;
            o_code_bits  <= '0;
            o_code_last  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sr_q         <= sr_d;
            tail_q       <= tail_d;
            o_code_valid <= valid_d;
            o_code_bits  <= bits_d;
            o_code_last  <= last_d;
        end
    end

    // Next-state and slot loading; nothing moves while the slot is stalled.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        tail_d  = tail_q;
        valid_d = o_code_valid & ~i_code_ready;
        bits_d  = o_code_bits;
        last_d  = o_code_last;

        case (state_q)
            S_IDLE, S_DATA: begin
                if (accept) begin
                    valid_d = 1'b1;
                    bits_d  = enc_sym;
                    last_d  = 1'b0;
                    sr_d    = {i_data_bit, sr_q[SR_W-1:1]};
                    tail_d  = '0;
                    state_d = i_data_last ? S_TAIL : S_DATA;
                end
            end
            S_TAIL: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    bits_d  = enc_sym;
                    last_d  = 1'b0;
                    sr_d    = {1'b0, sr_q[SR_W-1:1]};
                    tail_d  = tail_q + TAIL_W'(1);
                    if (tail_q == TAIL_W'(K - 2)) begin
                        last_d  = 1'b1;
                        tail_d  = '0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule
